// File: rtl/hamming_encoder_tx.sv
// Hamming(7,4) encoder with an MSB-first serializer, each bit held DIV clocks.
// Define HAMMING_SECDED_EN to add an overall even-parity bit (8-bit codeword, sent first).
module hamming_encoder_tx #(
  parameter int DIV = 1,
`ifdef HAMMING_SECDED_EN
  localparam int N = 8
`else
  localparam int N = 7
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [N-1:0] cw_out,
  output logic         cw_valid,
  output logic         sdo,
  output logic         sdo_en,
  output logic         frame_done
);

  localparam logic [7:0] DIV_M1   = 8'(DIV - 1);
  localparam logic [2:0] LAST_BIT = 3'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [N-1:0] cw_next;

  function automatic logic [N-1:0] encode(input logic [3:0] d);
    logic [6:0] c;
    c = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
`ifdef HAMMING_SECDED_EN
    return {^c, c};
`else
    return c;
`endif
  endfunction

  assign cw_next   = encode(din);
  assign din_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      cw_out     <= '0;
      cw_valid   <= 1'b0;
      sdo        <= 1'b0;
      sdo_en     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (din_valid) begin
            state    <= SHIFT;
            cw_out   <= cw_next;
            cw_valid <= 1'b1;
            sdo      <= cw_next[N-1];
            sdo_en   <= 1'b1;
            div_cnt  <= DIV_M1;
            bit_cnt  <= LAST_BIT;
          end
        end
        SHIFT: begin
          // frame_done is registered, so raise it one cycle ahead of bit 0's last clock
          frame_done <= ((bit_cnt == 3'd0) && (div_cnt == 8'd1)) ||
                        ((bit_cnt == 3'd1) && (div_cnt == 8'd0) && (DIV_M1 == 8'd0));
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else if (bit_cnt != 3'd0) begin
            div_cnt <= DIV_M1;
            bit_cnt <= bit_cnt - 3'd1;
            sdo     <= cw_out[bit_cnt - 3'd1];
          end else begin
            state      <= IDLE;
            cw_valid   <= 1'b0;
            sdo        <= 1'b0;
            sdo_en     <= 1'b0;
            frame_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Scoreboard bench: two encoders (DIV=1 and DIV=3) checked against a positional Hamming model.
module tb_hamming_encoder_tx;
`ifdef HAMMING_SECDED_EN
  localparam int N = 8;
`else
  localparam int N = 7;
`endif

  typedef struct {
    logic [3:0] d;
    logic [7:0] cw;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1;
  logic [3:0] din_a = '0, din_b = '0;
  logic vld_a = 1'b0, vld_b = 1'b0;
  logic rdy_a, rdy_b, cwv_a, cwv_b, sdo_a, sdo_b, sen_a, sen_b, fd_a, fd_b;
  logic [N-1:0] cw_a, cw_b;

  hamming_encoder_tx #(.DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_a), .din(din_a), .din_valid(vld_a), .din_ready(rdy_a),
    .cw_out(cw_a), .cw_valid(cwv_a), .sdo(sdo_a), .sdo_en(sen_a), .frame_done(fd_a));
  hamming_encoder_tx #(.DIV(3)) u_div3 (
    .clk(clk), .rst_n(rst_b), .din(din_b), .din_valid(vld_b), .din_ready(rdy_b),
    .cw_out(cw_b), .cw_valid(cwv_b), .sdo(sdo_b), .sdo_en(sen_b), .frame_done(fd_b));

  logic rst_x[2], rdy_x[2], cwv_x[2], sdo_x[2], sen_x[2], fd_x[2];
  logic [7:0] cw_x[2];
  assign rst_x[0] = rst_a;  assign rst_x[1] = rst_b;
  assign rdy_x[0] = rdy_a;  assign rdy_x[1] = rdy_b;
  assign cwv_x[0] = cwv_a;  assign cwv_x[1] = cwv_b;
  assign sdo_x[0] = sdo_a;  assign sdo_x[1] = sdo_b;
  assign sen_x[0] = sen_a;  assign sen_x[1] = sen_b;
  assign fd_x[0]  = fd_a;   assign fd_x[1]  = fd_b;
  assign cw_x[0]  = 8'(cw_a);
  assign cw_x[1]  = 8'(cw_b);

  exp_t q0[$];
  exp_t q1[$];
  bit   in_frame[2];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Codeword position p (1..7) lives at bit p-1; data at 3,5,6,7; parity at 1,2,4.
  function automatic logic [7:0] model(input logic [3:0] d);
    logic [7:0] pos;
    logic [7:0] cw;
    pos = '0;
    pos[3] = d[0]; pos[5] = d[1]; pos[6] = d[2]; pos[7] = d[3];
    for (int p = 1; p <= 4; p = p * 2)
      for (int j = 3; j <= 7; j++)
        if ((j & p) != 0) pos[p] = pos[p] ^ pos[j];
    cw = '0;
    for (int i = 1; i <= 7; i++) cw[i-1] = pos[i];
`ifdef HAMMING_SECDED_EN
    cw[7] = ^cw[6:0];
`endif
    return cw;
  endfunction

  function automatic logic [7:0] ext(input logic [6:0] c);
`ifdef HAMMING_SECDED_EN
    return {^c, c};
`else
    return {1'b0, c};
`endif
  endfunction

  function automatic logic [2:0] syndrome(input logic [7:0] cw);
    logic [2:0] s;
    s = '0;
    for (int i = 1; i <= 7; i++) if (cw[i-1]) s = s ^ 3'(i);
    return s;
  endfunction

  task automatic push(input int k, input logic [3:0] d, input logic [7:0] e);
    exp_t x;
    x.d = d;
    x.cw = e;
    if (k == 0) q0.push_back(x); else q1.push_back(x);
  endtask

  task automatic monitor(input int k, input int div);
    exp_t e;
    int t;
    logic [7:0] cwv;
    t = 0;
    forever begin
      @(negedge clk);
      if (!rst_x[k]) begin
        in_frame[k] = 1'b0;
        chk("reset_outputs", {cw_x[k], cwv_x[k], sdo_x[k], sen_x[k], fd_x[k]}, 32'h0);
        chk("reset_ready", 32'(rdy_x[k]), 32'h1);
      end else if (sen_x[k]) begin
        if (!in_frame[k]) begin
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            chk("unexpected_frame", 32'h1, 32'h0);
            e.d = '0;
            e.cw = cw_x[k];
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
          end
          in_frame[k] = 1'b1;
          t = 0;
          chk("cw_out", 32'(cw_x[k]), 32'(e.cw));
          chk("syndrome", 32'(syndrome(cw_x[k])), 32'h0);
          chk("decoded", 32'({cw_x[k][6], cw_x[k][5], cw_x[k][4], cw_x[k][2]}), 32'(e.d));
`ifdef HAMMING_SECDED_EN
          chk("overall_parity", 32'(^cw_x[k]), 32'h0);
`endif
        end
        cwv = e.cw;
        if (t < N * div) chk("sdo_bit", 32'(sdo_x[k]), 32'(cwv[N - 1 - t / div]));
        else chk("frame_overrun", 32'(t), 32'(N * div - 1));
        chk("cw_stable", 32'(cw_x[k]), 32'(e.cw));
        chk("cw_valid", 32'(cwv_x[k]), 32'h1);
        chk("ready_low", 32'(rdy_x[k]), 32'h0);
        chk("frame_done", 32'(fd_x[k]), 32'(t == N * div - 1));
        t++;
      end else begin
        if (in_frame[k]) begin
          in_frame[k] = 1'b0;
          chk("frame_len", 32'(t), 32'(N * div));
          chk("cw_retained", 32'(cw_x[k]), 32'(e.cw));
        end
        chk("idle_outputs", {cwv_x[k], sdo_x[k], fd_x[k], rdy_x[k]}, 32'h1);
      end
    end
  endtask

  task automatic drive(input int k, input logic [3:0] d, input logic [7:0] e);
    int w;
    w = 0;
    @(negedge clk);
    while (!rdy_x[k] && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("ready_timeout", 32'(w < 500), 32'h1);
    if (k == 0) begin din_a = d; vld_a = 1'b1; end
    else begin din_b = d; vld_b = 1'b1; end
    push(k, d, e);
    @(negedge clk);
    chk("latency", {cwv_x[k], sen_x[k], rdy_x[k]}, 32'h6);
    if (k == 0) begin vld_a = 1'b0; din_a = 4'($urandom); end
    else begin vld_b = 1'b0; din_b = 4'($urandom); end
  endtask

  initial begin
    logic [3:0] d;
    int k;
    int w;
    time t0;
    fork
      monitor(0, 1);
      monitor(1, 3);
    join_none

    #1 rst_a = 1'b0; rst_b = 1'b0;
    #1 chk("async_reset", {cw_x[0], cw_x[1], cwv_a, cwv_b, sdo_a, sdo_b, sen_a, sen_b, fd_a, fd_b}, 32'h0);
    repeat (3) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {rdy_a, rdy_b}, 32'h3);

    drive(0, 4'h2, ext(7'b0011001));
    for (int i = 0; i < 16; i++) drive(0, 4'(i), model(4'(i)));
    drive(1, 4'hF, ext(7'b1111111));

    for (int i = 0; i < 24; i++) begin
      k = int'($urandom_range(0, 1));
      d = 4'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      drive(k, d, model(d));
    end

    // back-to-back accepts with din_valid held high
    @(negedge clk);
    w = 0;
    while (!rdy_b && w < 500) begin @(negedge clk); w++; end
    din_b = 4'h1; vld_b = 1'b1;
    push(1, 4'h1, ext(7'b0000111));
    t0 = $time;
    @(negedge clk);
    din_b = 4'h8;
    w = 0;
    while (!rdy_b && w < 500) begin @(negedge clk); w++; end
    push(1, 4'h8, ext(7'b1001011));
    chk("throughput", 32'(($time - t0) / 10), 32'(N * 3 + 1));
    @(negedge clk);
    vld_b = 1'b0;

    // abort a frame with reset while bit index 3 is on the wire
    d = 4'($urandom);
    drive(1, d, model(d));
    repeat (10) @(posedge clk);
    #2 rst_b = 1'b0;
    #1 chk("abort_reset", {cw_x[1], cwv_b, sdo_b, sen_b, fd_b}, 32'h0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    drive(1, 4'h2, ext(7'b0011001));

    w = 0;
    while ((q0.size() != 0 || q1.size() != 0 || in_frame[0] || in_frame[1]) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_timeout", 32'(w < 3000), 32'h1);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/hamming_encoder_tx.md
HAMMING_ENCODER_TX -- requirements
Module: hamming_encoder_tx

Interface
REQ-001 The block SHALL have parameter DIV, default 1, meaning clk cycles per serial bit (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port din, input, 4, data nibble to encode.
REQ-005 The block SHALL have port din_valid, input, 1, din presented.
REQ-006 The block SHALL have port din_ready, output, 1, block can accept a nibble.
REQ-007 The block SHALL have port cw_out, output, N (7, or 8 with macro), registered parallel codeword.
REQ-008 The block SHALL have port cw_valid, output, 1, cw_out holds the codeword currently being serialized.
REQ-009 The block SHALL have port sdo, output, 1, serial codeword bit.
REQ-010 The block SHALL have port sdo_en, output, 1, sdo carries a valid bit.
REQ-011 The block SHALL have port frame_done, output, 1, one-cycle pulse at end of frame.

Function
REQ-012 Encoding SHALL be c0=d0^d1^d3, c1=d0^d2^d3, c2=d0, c3=d1^d2^d3, c4=d1, c5=d2, c6=d3, where d=din; cw_out[6:0]=c6..c0 (compatible with hamming_decoder bit order).
REQ-013 The FSM SHALL have states IDLE and SHIFT; IDLE->SHIFT on din_valid&&din_ready; SHIFT->IDLE after the last bit period completes.
REQ-014 din_ready SHALL be 1 in IDLE and 0 in SHIFT; din is ignored when din_valid=0 or din_ready=0.
REQ-015 Latency: cw_out, cw_valid=1, sdo_en=1 and the first sdo bit SHALL appear on the cycle after the accepting edge.
REQ-016 Bits SHALL be shifted MSB first (cw_out[N-1] down to cw_out[0]), each held exactly DIV clk cycles via a bit-period counter that reloads on every bit.
REQ-017 A bit counter SHALL count 0..N-1; frame_done SHALL pulse high for one cycle during the final clk of bit 0's period, the same cycle sdo_en is last high.
REQ-018 On the cycle after frame_done, the block SHALL be in IDLE with din_ready=1, sdo_en=0, cw_valid=0, sdo=0; cw_out retains its last value.
REQ-019 Throughput SHALL be one nibble per N*DIV+1 cycles when din_valid is held high.
REQ-020 cw_out SHALL be stable throughout SHIFT; changes on din during SHIFT SHALL have no effect.
REQ-021 With DIV=1, consecutive sdo bits SHALL change every clk cycle with no gaps.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, din_ready=1 (after release, combinationally from state), cw_out=0, cw_valid=0, sdo=0, sdo_en=0, frame_done=0, and both counters=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse; the next accepted nibble starts a fresh frame from the MSB.

Configuration
REQ-024 Macro HAMMING_SECDED_EN, when defined, SHALL set N=8 with cw_out[7]=XOR of c6..c0 (overall even parity), serialized first.
REQ-025 Without HAMMING_SECDED_EN, N SHALL be 7 and no parity bit logic SHALL exist.

Verification
REQ-026 Bench SHALL check: reset, DIV=1, din=4'h2 valid one cycle -> next cycle cw_out=7'b0011001, sdo sequence 0,0,1,1,0,0,1, frame_done on 7th sdo_en cycle.
REQ-027 Bench SHALL check: exhaustive din 0..F -> every cw_out decodes with zero syndrome in hamming_decoder, decoded data equal to din.
REQ-028 Bench SHALL check: DIV=3, din=4'hF -> cw_out=7'b1111111, each bit held 3 cycles, sdo_en high 21 cycles, din_ready low for 21 cycles.
REQ-029 Bench SHALL check: din_valid held high with din=4'h1 then 4'h8 -> second accept exactly N*DIV+1 cycles after the first, cw_out=7'b0000111 then 7'b1001011.
REQ-030 Bench SHALL check: rst_n pulsed low at bit 3 of a frame -> all outputs 0 asynchronously, no frame_done, next frame starts from the MSB.
REQ-031 Bench SHALL check: with HAMMING_SECDED_EN, din=4'h2 -> cw_out=8'b10011001, first sdo bit 1, frame length 8 bits.
